// File: rtl/serial_sym_pkg.sv
// ============================================================================
// Module  : serial_sym_pkg
// Brief   : Shared FSM encodings and counter constants for serial_sym_tx.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package serial_sym_pkg;

  // Two-state transmitter FSM, explicit 1-bit encoding
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Width of the bit-period divider counter
  localparam int DIV_W = 16;

  // Completed-symbol counter wraps from this value back to zero
  localparam logic [4:0] SYM_CNT_WRAP = 5'd19;

  // Next value of the modulo-20 completed-symbol counter
  function automatic logic [4:0] sym_cnt_next(input logic [4:0] cnt);
    return (cnt == SYM_CNT_WRAP) ? 5'd0 : cnt + 5'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_tick_gen.sv
// ============================================================================
// Module  : bit_tick_gen
// Brief   : Bit-period divider. Counts 0..BIT_DIV-1 while enabled and flags
//           the last cycle (tick) and the one before it (pre_tick).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bit_tick_gen
  import serial_sym_pkg::*;
#(
  parameter int BIT_DIV = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(BIT_DIV - 2);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter: restarts on clear, free-runs modulo BIT_DIV while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clear || !en) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Period markers; pre_tick lets the parent register a pulse that lands on the last cycle
  always_comb begin
    tick     = en && (div_cnt == DIV_LAST);
    pre_tick = en && (div_cnt == DIV_PRE);
  end

endmodule

`default_nettype wire

// File: rtl/serial_sym_tx.sv
// ============================================================================
// Module  : serial_sym_tx
// Brief   : Symbol serializer. Accepts SYM_W-bit symbols over a valid/ready
//           handshake and shifts them out MSB first, BIT_DIV clocks per bit,
//           with gapless back-to-back reload at the end of the last bit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_sym_tx
  import serial_sym_pkg::*;
#(
  parameter int BIT_DIV = 500,
  parameter int SYM_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             data_out,
  output logic             busy,
  output logic             sym_done,
  output logic [4:0]       sym_cnt
);

  localparam int              IDX_W    = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SYM_W-1:0]   shreg;
  logic [SYM_W-1:0]   shreg_shl;
  logic [IDX_W-1:0]   bit_idx;
  logic               last_bit;
  logic               handshake;
  logic               tick;
  logic               pre_tick;
  logic               shifting;

  assign shifting  = (state == ST_SHIFT);
  assign last_bit  = (bit_idx == IDX_LAST);
  assign handshake = sym_valid && sym_ready;
  assign shreg_shl = shreg << 1;

  bit_tick_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (handshake),
    .en       (shifting),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: leave IDLE on handshake, leave SHIFT only at symbol end without a new one
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick && last_bit) begin
          state_nxt = handshake ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready when idle or on the final cycle of the final bit
  always_comb begin
    sym_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        sym_ready = 1'b1;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        sym_ready = tick && last_bit;
      end
      default: begin
        sym_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Shift datapath: load on handshake, advance one bit per tick, idle high afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_idx  <= '0;
      data_out <= 1'b1;
    end else if (handshake) begin
      shreg    <= sym_in;
      bit_idx  <= '0;
      data_out <= sym_in[SYM_W-1];
    end else if (shifting && tick) begin
      if (last_bit) begin
        shreg    <= '0;
        bit_idx  <= '0;
        data_out <= 1'b1;
      end else begin
        shreg    <= shreg_shl;
        bit_idx  <= bit_idx + IDX_W'(1);
        data_out <= shreg_shl[SYM_W-1];
      end
    end
  end

  // Completion pulse registered one cycle early so it sits on the last cycle of the last bit;
  // the counter advances when the pulse is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_done <= 1'b0;
      sym_cnt  <= 5'd0;
    end else begin
      sym_done <= shifting && last_bit && pre_tick;
      if (sym_done) begin
        sym_cnt <= sym_cnt_next(sym_cnt);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sym_tx.sv
// ============================================================================
// Module  : tb_serial_sym_tx
// Brief   : Self-checking bench for serial_sym_tx with BIT_DIV=4, SYM_W=4.
//           A cycle-indexed reference model predicts every output from the
//           handshake times and the symbol bits.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_sym_tx;

  localparam int BD = 4;
  localparam int SW = 4;
  localparam int SYM_CYC = BD * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sym_in;
  logic          sym_valid;
  logic          sym_ready;
  logic          data_out;
  logic          busy;
  logic          sym_done;
  logic [4:0]    sym_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            m_active;
  int            m_start;
  logic [SW-1:0] m_sym;
  int            m_cnt;
  int            m_cyc;
  bit            hs_taken;

  // Per-cycle samples: {data_out, sym_done, busy, sym_ready, sym_cnt}
  logic [8:0]    obs_v;
  logic [8:0]    exp_v;
  logic          obs_data;
  logic          obs_done;
  logic [4:0]    obs_cnt;

  serial_sym_tx #(
    .BIT_DIV (BD),
    .SYM_W   (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .data_out  (data_out),
    .busy      (busy),
    .sym_done  (sym_done),
    .sym_cnt   (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0;
    m_start  = 0;
    m_sym    = '0;
    m_cnt    = 0;
    m_cyc    = 0;
    hs_taken = 0;
  endtask

  // One clock: sample DUT at negedge, predict, then advance model at posedge
  task automatic step();
    int   off;
    logic e_data, e_done, e_busy, e_ready;
    @(negedge clk);
    obs_v    = {data_out, sym_done, busy, sym_ready, sym_cnt};
    obs_data = data_out;
    obs_done = sym_done;
    obs_cnt  = sym_cnt;
    if (m_active) begin
      off     = m_cyc - m_start - 1;
      e_data  = m_sym[SW-1-(off/BD)];
      e_done  = (off == SYM_CYC - 1);
      e_busy  = 1'b1;
      e_ready = e_done;
    end else begin
      e_data  = 1'b1;
      e_done  = 1'b0;
      e_busy  = 1'b0;
      e_ready = 1'b1;
    end
    exp_v = {e_data, e_done, e_busy, e_ready, 5'(m_cnt)};
    @(posedge clk);
    hs_taken = 0;
    if (e_done) m_cnt = (m_cnt + 1) % 20;
    if (sym_valid && e_ready) begin
      m_active = 1;
      m_start  = m_cyc;
      m_sym    = sym_in;
      hs_taken = 1;
    end else if (e_done) begin
      m_active = 0;
    end
    m_cyc++;
    #1;
  endtask

  task automatic apply_reset();
    sym_valid = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sym_valid = 1'b0;
    sym_in = '0;
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (data_out !== 1'b1) begin n_err++; $display("FAIL reset_data got=%b want=1", data_out); end
    n_cmp++; if (sym_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", sym_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (sym_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", sym_done); end
    n_cmp++; if (sym_cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", sym_cnt); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [16:0] wave = '0;
    logic [16:0] dn   = '0;
    sym_valid = 1'b1;
    sym_in    = 4'b1011;
    step();
    n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL single_hs got=%b want=%b", obs_v, exp_v); end
    sym_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      sym_in = SW'($urandom);
      step();
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL single_cyc%0d got=%b want=%b", i + 1, obs_v, exp_v); end
      wave = {wave[15:0], obs_data};
      dn   = {dn[15:0], obs_done};
    end
    n_cmp++; if (wave !== 17'b1111_0000_1111_1111_1) begin n_err++; $display("FAIL single_wave got=%b want=%b", wave, 17'b11110000111111111); end
    n_cmp++; if (dn !== 17'b0000_0000_0000_0001_0) begin n_err++; $display("FAIL single_done got=%b want=%b", dn, 17'b00000000000000010); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wave = '0;
    int hs_n = 0;
    int dn_n = 0;
    sym_valid = 1'b1;
    sym_in    = 4'b1001;
    step();
    if (hs_taken) hs_n++;
    sym_in = 4'b0110;
    for (int i = 1; i <= 34; i++) begin
      sym_valid = (hs_n < 2);
      step();
      if (hs_taken) hs_n++;
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL b2b_cyc%0d got=%b want=%b", i, obs_v, exp_v); end
      if (i <= 32) wave = {wave[30:0], obs_data};
      if (obs_done) dn_n++;
    end
    n_cmp++; if (wave !== 32'hF00F_0FF0) begin n_err++; $display("FAIL b2b_wave got=%h want=F00F0FF0", wave); end
    n_cmp++; if (dn_n != 2) begin n_err++; $display("FAIL b2b_done_count got=%0d want=2", dn_n); end
  endtask

  task automatic test_ignore_midsym();
    logic [SW-1:0]      a;
    logic [SYM_CYC-1:0] wave = '0;
    logic [SYM_CYC-1:0] want = '0;
    int dn_n = 0;
    a = SW'($urandom);
    for (int b = 0; b < SYM_CYC; b++) want[SYM_CYC-1-b] = a[SW-1-(b/BD)];
    sym_valid = 1'b1;
    sym_in    = a;
    step();
    for (int i = 1; i <= 18; i++) begin
      sym_valid = (i <= SYM_CYC - 1);
      sym_in    = SW'($urandom);
      step();
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL ignore_cyc%0d got=%b want=%b", i, obs_v, exp_v); end
      if (i <= SYM_CYC) wave = {wave[SYM_CYC-2:0], obs_data};
      if (obs_done) dn_n++;
    end
    n_cmp++; if (wave !== want) begin n_err++; $display("FAIL ignore_wave got=%b want=%b", wave, want); end
    n_cmp++; if (dn_n != 1) begin n_err++; $display("FAIL ignore_done_count got=%0d want=1", dn_n); end
  endtask

  task automatic test_reset_midsym();
    apply_reset();
    sym_valid = 1'b1;
    sym_in    = SW'($urandom);
    step();
    sym_valid = 1'b0;
    for (int i = 1; i <= 2 * BD; i++) begin
      step();
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL rstmid_pre%0d got=%b want=%b", i, obs_v, exp_v); end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({data_out, sym_done, busy, sym_ready, sym_cnt} !== 9'b1_0_0_1_00000)
      begin n_err++; $display("FAIL rstmid_async got=%b want=100100000", {data_out, sym_done, busy, sym_ready, sym_cnt}); end
    @(negedge clk);
    n_cmp++; if ({data_out, sym_done, busy, sym_cnt} !== 8'b1_0_0_00000)
      begin n_err++; $display("FAIL rstmid_hold got=%b want=10000000", {data_out, sym_done, busy, sym_cnt}); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sym_valid = 1'b1;
    sym_in    = SW'($urandom);
    step();
    sym_valid = 1'b0;
    for (int i = 1; i <= SYM_CYC + 2; i++) begin
      step();
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL rstmid_post%0d got=%b want=%b", i, obs_v, exp_v); end
    end
    n_cmp++; if (obs_cnt !== 5'd1) begin n_err++; $display("FAIL rstmid_cnt got=%0d want=1", obs_cnt); end
  endtask

  task automatic test_twenty();
    logic [SW-1:0] q[$];
    int  seen = 0;
    bit  prev_done = 0;
    int  guard = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) q.push_back(SW'($urandom));
    while (!(seen == 20 && !prev_done) && guard < 400) begin
      sym_valid = (q.size() > 0);
      sym_in    = (q.size() > 0) ? q[0] : '0;
      step();
      guard++;
      if (hs_taken) void'(q.pop_front());
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL twenty_cyc%0d got=%b want=%b", guard, obs_v, exp_v); end
      if (prev_done) begin
        n_cmp++; if (obs_cnt !== 5'(seen % 20)) begin n_err++; $display("FAIL twenty_cnt got=%0d want=%0d", obs_cnt, seen % 20); end
      end
      prev_done = obs_done;
      if (obs_done) seen++;
    end
    n_cmp++; if (seen != 20) begin n_err++; $display("FAIL twenty_timeout got=%0d want=20", seen); end
  endtask

  task automatic test_random();
    logic [SW-1:0] q[$];
    int guard = 0;
    for (int i = 0; i < 25; i++) q.push_back(SW'($urandom));
    while ((q.size() > 0 || m_active) && guard < 1000) begin
      sym_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      sym_in    = (q.size() > 0) ? q[0] : SW'($urandom);
      step();
      guard++;
      if (hs_taken) void'(q.pop_front());
      n_cmp++; if (obs_v !== exp_v) begin n_err++; $display("FAIL random_cyc%0d got=%b want=%b", guard, obs_v, exp_v); end
    end
    n_cmp++; if (q.size() != 0 || m_active) begin n_err++; $display("FAIL random_timeout left=%0d want=0", q.size()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midsym();
    test_reset_midsym();
    test_twenty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sym_tx.md
SERIAL_SYM_TX -- requirements
Module: serial_sym_tx

Interface
REQ-001 SHALL have parameter BIT_DIV, default 500, clk cycles per serial bit period; legal range 2..65535.
REQ-002 SHALL have parameter SYM_W, default 4, bits per symbol, MSB first.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sym_in  input  SYM_W  symbol to serialize; sampled only on handshake.
REQ-006 SHALL have port sym_valid  input  1  producer has a symbol on sym_in.
REQ-007 SHALL have port sym_ready  output  1  block accepts sym_in this cycle.
REQ-008 SHALL have port data_out  output  1  registered serial line, idle level 1.
REQ-009 SHALL have port busy  output  1  high while a symbol is being shifted.
REQ-010 SHALL have port sym_done  output  1  one-cycle pulse on the final cycle of a symbol's last bit.
REQ-011 SHALL have port sym_cnt  output  5  count of completed symbols, modulo 20.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-013 Handshake SHALL occur on a rising edge where sym_valid and sym_ready are both 1; sym_in is latched into the shift register then.
REQ-014 sym_ready SHALL be 1 in IDLE, and in SHIFT only on the last clock of the last bit period; 0 otherwise.
REQ-015 IDLE + handshake SHALL go to SHIFT; data_out SHALL show sym_in[SYM_W-1] from the next cycle (latency 1).
REQ-016 Each bit SHALL be held on data_out for exactly BIT_DIV cycles, using a 16-bit divider counting 0..BIT_DIV-1 and a bit index counting 0..SYM_W-1.
REQ-017 At the end of the last bit with a handshake, SHALL reload and stay in SHIFT, so the next MSB follows with no gap cycle.
REQ-018 At the end of the last bit without a handshake, SHALL return to IDLE with data_out=1 on the next cycle.
REQ-019 sym_valid while sym_ready=0 SHALL be ignored; changes on sym_in mid-symbol SHALL NOT affect data_out.
REQ-020 sym_cnt SHALL increment on each sym_done and wrap 19->0.
REQ-021 busy SHALL equal (state==SHIFT).

Reset
REQ-022 rst=1 SHALL immediately force: state IDLE, data_out=1, sym_ready=1, busy=0, sym_done=0, sym_cnt=0, divider/bit index/shift register=0.
REQ-023 Reset asserted mid-symbol SHALL abort the symbol without a sym_done pulse or count increment.
REQ-024 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-025 FSM state encodings and the sym_cnt wrap constant (19) SHALL live in a shared package, e.g. serial_sym_pkg.
REQ-026 The bit-period divider SHALL be one sub-module, bit_tick_gen, producing a one-cycle tick on the last divider cycle; it is cleared on handshake.
REQ-027 No other sub-modules; all outputs driven from registers except sym_ready.

Verification (BIT_DIV=4, SYM_W=4)
REQ-028 Reset: assert rst mid-clock -> data_out=1, sym_ready=1, busy=0, sym_cnt=0 at once, without waiting for a clock edge.
REQ-029 Single symbol 4'b1011 -> data_out 1,0,1,1, each for 4 cycles, starting the cycle after handshake; sym_done on cycle 16; idle 1 on cycle 17.
REQ-030 Back-to-back: 4'b1001 then 4'b0110 with sym_valid held -> 32 contiguous cycles 1,0,0,1,0,1,1,0 (x4 each), no idle-1 gap; two sym_done pulses.
REQ-031 sym_valid=1 with sym_in changing during SHIFT -> no extra handshake, transmitted bits unchanged.
REQ-032 Twenty symbols -> sym_cnt steps 1..19 then 0.
REQ-033 rst pulsed at bit 2 of a symbol -> immediate idle, no sym_done, sym_cnt unchanged at 0; next symbol transmits correctly.
